// File: rtl/kb_pkg.sv
// Shared constants for the keyboard input FIFO: key-code width, default depth
// and the occupancy-counter width helper.
package kb_pkg;

  localparam int KB_ASCII_W        = 7;
  localparam int KB_FIFO_DEPTH_DEF = 16;
  localparam int KB_CNT_W_DEF      = $clog2(KB_FIFO_DEPTH_DEF + 1);

  // The counter must hold the value DEPTH itself, hence depth+1 states.
  function automatic int kb_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/kb_fifo_mem.sv
// Key-code storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the FIFO masks stale entries.
module kb_fifo_mem
  import kb_pkg::*;
#(
  parameter int DATA_W = KB_ASCII_W,
  parameter int DEPTH  = KB_FIFO_DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port; no reset so the array maps onto plain RAM/registers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/kb_input_fifo.sv
// First-word-fall-through FIFO between the key decoder and the CPU I/O side.
// Define KB_FIFO_OVERFLOW_EN to build the sticky overflow flag; otherwise overflow is tied low.
module kb_input_fifo
  import kb_pkg::*;
#(
  parameter int DATA_W = KB_ASCII_W,
  parameter int DEPTH  = KB_FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_strobe,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  input  logic                       clear,
  output logic                       status,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = kb_cnt_w(DEPTH);

  logic              wr_q;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              push_s;
  logic              pop_s;
  logic              accept_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] head_s;

  assign status = (count_r != {CNT_W{1'b0}});
  assign full   = (count_r == CNT_W'(DEPTH));
  assign count  = count_r;

  // A held strobe only pushes on its first cycle; pops on an empty FIFO are ignored.
  assign push_s   = wr_strobe & ~wr_q;
  assign pop_s    = rd_en & status;
  // When full, a push is only accepted if a pop frees the head slot in the same edge.
  assign accept_s = push_s & (~full | pop_s);
  assign mem_we_s = accept_s & ~clear;

  // Edge detector, pointers and occupancy; clear overrides push/pop but not wr_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q     <= 1'b0;
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_q <= wr_strobe;
      if (clear) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (accept_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
        case ({accept_s, pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

`ifdef KB_FIFO_OVERFLOW_EN
  logic overflow_r;
  logic drop_s;

  assign drop_s   = push_s & full & ~pop_s;
  assign overflow = overflow_r;

  // Sticky record of any push lost to a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (clear) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end
`else
  assign overflow = 1'b0;
`endif

  kb_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_r),
    .rd_data (head_s)
  );

  // Storage is never reset, so the head is hidden whenever the FIFO is empty.
  assign rd_data = status ? head_s : {DATA_W{1'b0}};

endmodule

// File: doc/kb_input_fifo.md
KB_INPUT_FIFO -- requirements
Module: kb_input_fifo

Interface
REQ-001 Parameter DATA_W, default 7, SHALL set the width of each stored key code in bits (legal range 1..16).
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count (power of two, at least 2).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state SHALL change on the rising edge only.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port wr_strobe, input, 1 bit, SHALL be the new-code indication from the decoder; it may be held high for multiple cycles.
REQ-006 Port wr_data, input, DATA_W bits, SHALL be the code sampled on a push.
REQ-007 Port rd_en, input, 1 bit, SHALL be the pop request from the CPU I/O side.
REQ-008 Port clear, input, 1 bit, SHALL be the synchronous flush request.
REQ-009 Port status, output, 1 bit, SHALL indicate the FIFO is non-empty.
REQ-010 Port rd_data, output, DATA_W bits, SHALL carry the head entry.
REQ-011 Port full, output, 1 bit, SHALL indicate count equals DEPTH.
REQ-012 Port count, output, $clog2(DEPTH+1) bits, SHALL carry the current occupancy.
REQ-013 Port overflow, output, 1 bit, SHALL be the sticky overflow flag (see Configuration).

Function
REQ-014 The block SHALL push only on a rising edge of wr_strobe: wr_strobe is 1 and the registered previous value wr_q is 0. A held strobe SHALL push exactly once.
REQ-015 A push SHALL store wr_data at the write pointer; status, count and rd_data SHALL reflect it in the cycle after the accepting edge (1-cycle latency).
REQ-016 The FIFO SHALL be first-word-fall-through: rd_data SHALL equal the head entry whenever status=1, and all zeros when status=0.
REQ-017 rd_en=1 with status=1 SHALL pop the head at the clock edge; rd_en=1 with status=0 SHALL be ignored with no pointer or count change.
REQ-018 A push while full with no simultaneous pop SHALL be dropped; contents, pointers and count SHALL be unchanged.
REQ-019 A simultaneous push and pop while full SHALL both take effect; count SHALL stay DEPTH.
REQ-020 A simultaneous push and pop while empty SHALL accept the push, ignore the pop, and leave count=1.
REQ-021 Simultaneous push and pop at any other occupancy SHALL leave count unchanged and advance both pointers.
REQ-022 Pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-023 clear=1 SHALL, at the next edge, zero the pointers and count. It SHALL dominate any push or pop in the same cycle. wr_q SHALL still update.
REQ-024 full SHALL equal (count==DEPTH); status SHALL equal (count!=0); both SHALL be derived from registered count with no combinational path from inputs.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately force pointers, count, wr_q and overflow to 0; status=0, full=0, rd_data=0, count=0.
REQ-026 Reset mid-operation SHALL discard all stored entries. After release, a wr_strobe already high SHALL be seen as a rising edge and pushed once.
REQ-027 Storage array contents need not be reset; rd_data masking (REQ-016) SHALL hide them.

Configuration
REQ-028 With macro KB_FIFO_OVERFLOW_EN defined, overflow SHALL set on any dropped push (REQ-018). It SHALL stay set until clear or reset.
REQ-029 Without KB_FIFO_OVERFLOW_EN, the overflow port SHALL remain present and be tied to 0, with no flag register instantiated.

Structure
REQ-030 Package kb_pkg SHALL hold KB_ASCII_W=7, KB_FIFO_DEPTH_DEF=16 and the count-width helper constant; the module SHALL take its parameter defaults from it.
REQ-031 Storage SHALL be a sub-module kb_fifo_mem: DEPTH x DATA_W, one synchronous write port, one asynchronous read port, no reset.
REQ-032 Edge detection, pointers, count and flags SHALL reside in kb_input_fifo.

Verification
REQ-033 Reset release, then wr_strobe high 5 cycles with wr_data=0x41 -> exactly one push; count=1, status=1, rd_data=0x41.
REQ-034 Push 0x31,0x32,0x33 (strobe pulses), then rd_en pulses -> rd_data sequence 0x31,0x32,0x33; status=0 and rd_data=0 after third pop.
REQ-035 DEPTH=4: push 0x10..0x14 -> full=1 after 4th; 5th dropped; overflow=1 with macro, 0 without; pops return 0x10..0x13.
REQ-036 Full FIFO, push 0x55 with rd_en in same cycle -> count stays 4, full=1; after 4 pops the last value is 0x55 (pointer wrap checked).
REQ-037 Count=3, push with clear=1 in same cycle -> count=0, status=0, overflow=0 next cycle.
REQ-038 Empty FIFO, push 0x20 with rd_en same cycle -> count=1, rd_data=0x20; then rst_n pulsed low mid-stream -> count=0 asynchronously.
